bp_be_regfile_mw: RTL and testbench
===================================

BP_BE_REGFILE_MW -- requirements
Module: bp_be_regfile_mw

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, selecting the proc config that supplies reg_addr_width_p.
REQ-002 SHALL have parameter data_width_p, default "inv", giving the register width in bits.
REQ-003 SHALL have parameter read_ports_p, default "inv", giving the read port count (1..4).
REQ-004 SHALL have parameter write_ports_p, default "inv", giving the write port count (1..2).
REQ-005 SHALL have parameter zero_reg_p, default 0; when 1, register 0 is hardwired zero.
REQ-006 SHALL have clk_i, input, 1 bit, as the single clock.
REQ-007 SHALL have reset_i, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have rs_r_v_i, input, [read_ports_p], per-port read request.
REQ-009 SHALL have rs_addr_i, input, [read_ports_p][reg_addr_width_p], read addresses.
REQ-010 SHALL have rs_data_o, output, [read_ports_p][data_width_p], read data.
REQ-011 SHALL have rd_w_v_i, input, [write_ports_p], per-port write valid.
REQ-012 SHALL have rd_addr_i, input, [write_ports_p][reg_addr_width_p], write addresses.
REQ-013 SHALL have rd_data_i, input, [write_ports_p][data_width_p], write data.
REQ-014 SHALL have rd_alloc_v_i, input, 1 bit, marking a destination as pending (scoreboard).
REQ-015 SHALL have rd_alloc_addr_i, input, [reg_addr_width_p], the destination to mark pending.
REQ-016 SHALL have rs_busy_o, output, [read_ports_p], pending status of rs_addr_i.

Function
REQ-017 Storage SHALL be 2**reg_addr_width_p flop entries with contents not reset; all write ports SHALL write on the same clock edge.
REQ-018 Same-cycle writes to the same address SHALL resolve so that the highest-index port wins.
REQ-019 Read latency SHALL be 1 cycle: rs_data_o[i] in cycle N+1 reflects rs_addr_i[i] sampled in cycle N when rs_r_v_i[i]=1.
REQ-020 A same-cycle read and write to the same address SHALL return the new write data the next cycle, using highest-index port priority.
REQ-021 When rs_r_v_i[i]=0, rs_data_o[i] SHALL hold the last read value.
REQ-022 While a value is held, a write to the held address SHALL replace the held value the next cycle.
REQ-023 When zero_reg_p=1, writes to address 0 SHALL be dropped and any read or hold of address 0 SHALL yield 0; this includes forwarding and replace.
REQ-024 rs_busy_o[i] SHALL be combinational: busy[rs_addr_i[i]] in the same cycle.

Reset
REQ-025 Asserting reset_i SHALL immediately clear the held data registers, read-valid flags and busy bits, so rs_data_o=0 and rs_busy_o=0; register contents are undefined.
REQ-026 Writes, reads and allocations during reset SHALL be ignored, including those in flight when reset asserts mid-operation.
REQ-027 The first read after deassertion SHALL behave per REQ-019.

Configuration
REQ-028 Macro BP_BE_REGFILE_SCOREBOARD_EN SHALL control the scoreboard.
REQ-029 With the macro defined:
- rd_alloc_v_i SHALL set busy[rd_alloc_addr_i].
- Any valid write SHALL clear busy[rd_addr_i].
- Alloc and clear of the same address in the same cycle SHALL leave it set.
- Alloc of address 0 with zero_reg_p=1 SHALL be ignored.
REQ-030 Without the macro, the ports SHALL remain, rd_alloc inputs SHALL be ignored, rs_busy_o SHALL be constant 0, and no busy flops SHALL exist.

Verification
REQ-031 Read-after-write: write x5=0xA5 in cycle 0, read x5 in cycle 1 -> rs_data_o=0xA5 in cycle 2.
REQ-032 Forward and priority: in one cycle write port0 x7=0x11, write port1 x7=0x22 and read x7 -> 0x22 next cycle; a later read of x7 -> 0x22.
REQ-033 Hold and replace: read x3=0x1 then drop rs_r_v_i for 3 cycles -> output stays 0x1; write x3=0x9 during the hold -> output 0x9 next cycle.
REQ-034 zero_reg_p=1: write x0=0xFF, then read x0 -> 0; same-cycle write+read of x0 -> 0.
REQ-035 Scoreboard: alloc x4 -> rs_busy_o=1 for x4; write x4 with a simultaneous re-alloc x4 -> stays 1; a lone write -> 0 next cycle; with the macro undefined -> always 0.
REQ-036 Async reset: assert reset_i mid-hold -> rs_data_o=0 and rs_busy_o=0 before the next clock edge.

Source files
------------

// File: rtl/bp_be_regfile_mw.sv
// ---------------------------------------------------------------------------
// bp_be_regfile_mw
//   Multi-port integer register file for the BlackParrot back end.
//   - 2**reg_addr_width_p flop entries. Entries are not reset.
//   - write_ports_p write ports, all applied on the same edge. When ports
//     target the same address, the highest-index port wins.
//   - read_ports_p read ports with one cycle of latency. A same-cycle write
//     is forwarded into the read result.
//   - Each read port holds its last result while its request is low. A write
//     to the held address replaces the held value on the next edge.
//   - zero_reg_p=1 hardwires register 0 to zero. Writes to x0 are dropped,
//     and reads or holds of x0 return 0.
//   - Optional pending-destination scoreboard, enabled by the compile-time
//     macro BP_BE_REGFILE_SCOREBOARD_EN. When the macro is not defined, the
//     alloc inputs are ignored and rs_busy_o is tied to 0.
//
//   The data_width_p, read_ports_p and write_ports_p defaults are only
//   placeholders so that the module elaborates on its own. The instantiating
//   core always overrides them.
//
// Ports
//   clk_i            clock
//   reset_i          asynchronous, active-high reset
//   rs_r_v_i         per-read-port request
//   rs_addr_i        per-read-port source address
//   rs_data_o        per-read-port data (registered)
//   rd_w_v_i         per-write-port valid
//   rd_addr_i        per-write-port destination address
//   rd_data_i        per-write-port write data
//   rd_alloc_v_i     mark rd_alloc_addr_i pending
//   rd_alloc_addr_i  destination to mark pending
//   rs_busy_o        per-read-port pending status of rs_addr_i (combinational)
// ---------------------------------------------------------------------------

package bp_be_regfile_mw_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  // Architectural register address width for each proc config
  function automatic int unsigned reg_addr_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg: return 32'd5;
      default:          return 32'd5;
    endcase
  endfunction

endpackage

module bp_be_regfile_mw
  import bp_be_regfile_mw_pkg::*;
#(
  parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned read_ports_p  = 2,
  parameter int unsigned write_ports_p = 1,
  parameter int unsigned zero_reg_p    = 0,
  localparam int unsigned reg_addr_width_p = reg_addr_width_f(bp_params_p)
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,

  input  logic [read_ports_p-1:0]                           rs_r_v_i,
  input  logic [read_ports_p-1:0][reg_addr_width_p-1:0]     rs_addr_i,
  output logic [read_ports_p-1:0][data_width_p-1:0]         rs_data_o,

  input  logic [write_ports_p-1:0]                          rd_w_v_i,
  input  logic [write_ports_p-1:0][reg_addr_width_p-1:0]    rd_addr_i,
  input  logic [write_ports_p-1:0][data_width_p-1:0]        rd_data_i,

  input  logic                                              rd_alloc_v_i,
  input  logic [reg_addr_width_p-1:0]                       rd_alloc_addr_i,
  output logic [read_ports_p-1:0]                           rs_busy_o
);

  localparam int unsigned num_regs_lp = 32'(1) << reg_addr_width_p;
  localparam logic        zero_en_lp  = (zero_reg_p != 0);

  // Effective write enables. Writes are dropped while in reset and, when
  // x0 is hardwired to zero, for writes that target x0.
  logic [write_ports_p-1:0] wr_en_c;

  always_comb begin
    wr_en_c = '0;
    for (int unsigned w = 0; w < write_ports_p; w++) begin
      wr_en_c[w] = rd_w_v_i[w] & ~reset_i
                 & ~(zero_en_lp & (rd_addr_i[w] == '0));
    end
  end

  // Register storage. No reset. Later loop iterations win, which gives the
  // higher-index write port priority.
  logic [data_width_p-1:0] mem_q [num_regs_lp];

  always_ff @(posedge clk_i) begin
    for (int unsigned w = 0; w < write_ports_p; w++) begin
      if (wr_en_c[w]) begin
        mem_q[rd_addr_i[w]] <= rd_data_i[w];
      end
    end
  end

  // Per-read-port output state: the held data, the held address and a flag
  // that a read has happened since reset.
  logic [read_ports_p-1:0]                       rs_v_q,    rs_v_d;
  logic [read_ports_p-1:0][reg_addr_width_p-1:0] rs_addr_q, rs_addr_d;
  logic [read_ports_p-1:0][data_width_p-1:0]     rs_data_q, rs_data_d;

  // Next read data. A new read returns the post-edge register value, with
  // same-cycle writes forwarded. A hold takes the data of any write to the
  // held address.
  always_comb begin
    rs_v_d    = rs_v_q;
    rs_addr_d = rs_addr_q;
    rs_data_d = rs_data_q;
    for (int unsigned i = 0; i < read_ports_p; i++) begin
      if (rs_r_v_i[i]) begin
        rs_v_d[i]    = 1'b1;
        rs_addr_d[i] = rs_addr_i[i];
        rs_data_d[i] = mem_q[rs_addr_i[i]];
        for (int unsigned w = 0; w < write_ports_p; w++) begin
          if (wr_en_c[w] && (rd_addr_i[w] == rs_addr_i[i])) begin
            rs_data_d[i] = rd_data_i[w];
          end
        end
        // x0 storage is never written and powers up unknown, so mask it here
        if (zero_en_lp && (rs_addr_i[i] == '0)) begin
          rs_data_d[i] = '0;
        end
      end else if (rs_v_q[i]) begin
        // wr_en_c already excludes x0, so a held zero register stays zero
        for (int unsigned w = 0; w < write_ports_p; w++) begin
          if (wr_en_c[w] && (rd_addr_i[w] == rs_addr_q[i])) begin
            rs_data_d[i] = rd_data_i[w];
          end
        end
      end
    end
  end

  // Read output state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rs_v_q    <= '0;
      rs_addr_q <= '0;
      rs_data_q <= '0;
    end else begin
      rs_v_q    <= rs_v_d;
      rs_addr_q <= rs_addr_d;
      rs_data_q <= rs_data_d;
    end
  end

  assign rs_data_o = rs_data_q;

`ifdef BP_BE_REGFILE_SCOREBOARD_EN
  // Pending-destination scoreboard. A write clears its destination first,
  // then alloc sets its destination, so alloc wins a same-address collision.
  logic [num_regs_lp-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < write_ports_p; w++) begin
      if (wr_en_c[w]) begin
        busy_d[rd_addr_i[w]] = 1'b0;
      end
    end
    if (rd_alloc_v_i && !(zero_en_lp && (rd_alloc_addr_i == '0))) begin
      busy_d[rd_alloc_addr_i] = 1'b1;
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Same-cycle lookup of the current source addresses
  always_comb begin
    rs_busy_o = '0;
    for (int unsigned i = 0; i < read_ports_p; i++) begin
      rs_busy_o[i] = busy_q[rs_addr_i[i]];
    end
  end
`else
  // Scoreboard compiled out. The alloc inputs are deliberately left unused.
  logic unused_alloc;
  assign unused_alloc = ^{rd_alloc_v_i, rd_alloc_addr_i};
  assign rs_busy_o    = '0;
`endif

endmodule

// File: tb/tb_bp_be_regfile_mw.sv
// ---------------------------------------------------------------------------
// tb_bp_be_regfile_mw
//   Directed bench for bp_be_regfile_mw. The DUT is configured with two read
//   ports, two write ports, 16-bit data and x0 hardwired to zero.
//   Expected busy values follow BP_BE_REGFILE_SCOREBOARD_EN.
// ---------------------------------------------------------------------------

module tb_bp_be_regfile_mw;

  localparam int unsigned DW = 16;
  localparam int unsigned RP = 2;
  localparam int unsigned WP = 2;
  localparam int unsigned AW = 5;

`ifdef BP_BE_REGFILE_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic                   clk_i;
  logic                   reset_i;
  logic [RP-1:0]          rs_r_v_i;
  logic [RP-1:0][AW-1:0]  rs_addr_i;
  logic [RP-1:0][DW-1:0]  rs_data_o;
  logic [WP-1:0]          rd_w_v_i;
  logic [WP-1:0][AW-1:0]  rd_addr_i;
  logic [WP-1:0][DW-1:0]  rd_data_i;
  logic                   rd_alloc_v_i;
  logic [AW-1:0]          rd_alloc_addr_i;
  logic [RP-1:0]          rs_busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_be_regfile_mw #(
    .data_width_p  (DW),
    .read_ports_p  (RP),
    .write_ports_p (WP),
    .zero_reg_p    (1)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .rs_r_v_i        (rs_r_v_i),
    .rs_addr_i       (rs_addr_i),
    .rs_data_o       (rs_data_o),
    .rd_w_v_i        (rd_w_v_i),
    .rd_addr_i       (rd_addr_i),
    .rd_data_i       (rd_data_i),
    .rd_alloc_v_i    (rd_alloc_v_i),
    .rd_alloc_addr_i (rd_alloc_addr_i),
    .rs_busy_o       (rs_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drop all valids. Addresses are kept so that busy lookups stay stable.
  task automatic clr();
    rs_r_v_i     = '0;
    rd_w_v_i     = '0;
    rd_alloc_v_i = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rs_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", rs_data_o);
    end
    n_cmp++;
    if (rs_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 00", rs_busy_o);
    end
  endtask

  task automatic test_raw();
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd5; rd_data_i[0] = 16'h00A5;
    tick();
    clr();
    rs_r_v_i = 2'b11; rs_addr_i[0] = 5'd5; rs_addr_i[1] = 5'd5;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h00A5) begin
      n_fail++;
      $display("FAIL raw_p0: got %h expected 00a5", rs_data_o[0]);
    end
    n_cmp++;
    if (rs_data_o[1] !== 16'h00A5) begin
      n_fail++;
      $display("FAIL raw_p1: got %h expected 00a5", rs_data_o[1]);
    end
  endtask

  task automatic test_fwd_priority();
    rd_w_v_i = 2'b11;
    rd_addr_i[0] = 5'd7; rd_data_i[0] = 16'h0011;
    rd_addr_i[1] = 5'd7; rd_data_i[1] = 16'h0022;
    rs_r_v_i = 2'b11; rs_addr_i[0] = 5'd7; rs_addr_i[1] = 5'd7;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0022) begin
      n_fail++;
      $display("FAIL fwd_p0: got %h expected 0022", rs_data_o[0]);
    end
    n_cmp++;
    if (rs_data_o[1] !== 16'h0022) begin
      n_fail++;
      $display("FAIL fwd_p1: got %h expected 0022", rs_data_o[1]);
    end
    // stored value must also reflect the priority
    rs_r_v_i[0] = 1'b1; rs_addr_i[0] = 5'd7;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0022) begin
      n_fail++;
      $display("FAIL prio_stored_x7: got %h expected 0022", rs_data_o[0]);
    end
    // a collision write without a read, then a read
    rd_w_v_i = 2'b11;
    rd_addr_i[0] = 5'd8; rd_data_i[0] = 16'h0033;
    rd_addr_i[1] = 5'd8; rd_data_i[1] = 16'h0044;
    tick();
    clr();
    rs_r_v_i[1] = 1'b1; rs_addr_i[1] = 5'd8;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[1] !== 16'h0044) begin
      n_fail++;
      $display("FAIL prio_stored_x8: got %h expected 0044", rs_data_o[1]);
    end
  endtask

  task automatic test_hold_replace();
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd3; rd_data_i[0] = 16'h0001;
    tick();
    clr();
    rs_r_v_i[0] = 1'b1; rs_addr_i[0] = 5'd3;
    tick();
    clr();
    rs_addr_i[0] = 5'd12;
    n_cmp++;
    if (rs_data_o[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL hold_read: got %h expected 0001", rs_data_o[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (rs_data_o[0] !== 16'h0001) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got %h expected 0001", k, rs_data_o[0]);
      end
    end
    rd_w_v_i[1] = 1'b1; rd_addr_i[1] = 5'd3; rd_data_i[1] = 16'h0009;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0009) begin
      n_fail++;
      $display("FAIL hold_replace: got %h expected 0009", rs_data_o[0]);
    end
    // a write to some other address must leave the held value alone
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd4; rd_data_i[0] = 16'h0077;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0009) begin
      n_fail++;
      $display("FAIL hold_other_write: got %h expected 0009", rs_data_o[0]);
    end
  endtask

  task automatic test_zero_reg();
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd0; rd_data_i[0] = 16'h00FF;
    tick();
    clr();
    rs_r_v_i[1] = 1'b1; rs_addr_i[1] = 5'd0;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_read: got %h expected 0000", rs_data_o[1]);
    end
    // load a non-zero value so the next check can see a change
    rs_r_v_i[1] = 1'b1; rs_addr_i[1] = 5'd5;
    tick();
    clr();
    rd_w_v_i[1] = 1'b1; rd_addr_i[1] = 5'd0; rd_data_i[1] = 16'h00FF;
    rs_r_v_i[1] = 1'b1; rs_addr_i[1] = 5'd0;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_fwd: got %h expected 0000", rs_data_o[1]);
    end
    // port 1 now holds x0, and a write to x0 must not replace it
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd0; rd_data_i[0] = 16'h0055;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_hold_replace: got %h expected 0000", rs_data_o[1]);
    end
  endtask

  task automatic test_scoreboard();
    rs_addr_i[0] = 5'd4; rs_addr_i[1] = 5'd6;
    rd_alloc_v_i = 1'b1; rd_alloc_addr_i = 5'd4;
    tick();
    clr();
    n_cmp++;
    if (rs_busy_o !== {1'b0, SB}) begin
      n_fail++;
      $display("FAIL sb_alloc: got %b expected %b", rs_busy_o, {1'b0, SB});
    end
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd4; rd_data_i[0] = 16'h0123;
    rd_alloc_v_i = 1'b1; rd_alloc_addr_i = 5'd4;
    tick();
    clr();
    n_cmp++;
    if (rs_busy_o !== {1'b0, SB}) begin
      n_fail++;
      $display("FAIL sb_realloc: got %b expected %b", rs_busy_o, {1'b0, SB});
    end
    rd_w_v_i[1] = 1'b1; rd_addr_i[1] = 5'd4; rd_data_i[1] = 16'h0456;
    tick();
    clr();
    n_cmp++;
    if (rs_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_clear: got %b expected 00", rs_busy_o);
    end
    // alloc of x0 is ignored while x0 is hardwired to zero
    rs_addr_i[0] = 5'd0;
    rd_alloc_v_i = 1'b1; rd_alloc_addr_i = 5'd0;
    tick();
    clr();
    n_cmp++;
    if (rs_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_alloc_x0: got %b expected 00", rs_busy_o);
    end
    // busy follows a change of the rs address within the same cycle
    rs_addr_i[1] = 5'd9;
    rd_alloc_v_i = 1'b1; rd_alloc_addr_i = 5'd6;
    tick();
    clr();
    rs_addr_i[1] = 5'd6;
    #1;
    n_cmp++;
    if (rs_busy_o !== {SB, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_comb_lookup: got %b expected %b", rs_busy_o, {SB, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    rs_r_v_i[0] = 1'b1; rs_addr_i[0] = 5'd3;
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0009) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %h expected 0009", rs_data_o[0]);
    end
    // assert reset partway through the cycle while a write and a read are applied
    #2;
    reset_i = 1'b1;
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd3; rd_data_i[0] = 16'h00BB;
    rs_r_v_i[0] = 1'b1; rs_addr_i[0] = 5'd3;
    #1;
    n_cmp++;
    if (rs_data_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %h expected 0", rs_data_o);
    end
    n_cmp++;
    if (rs_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_busy: got %b expected 00", rs_busy_o);
    end
    tick();
    n_cmp++;
    if (rs_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_read_ignored: got %h expected 0", rs_data_o);
    end
    clr();
    reset_i = 1'b0;
    tick();
    n_cmp++;
    if (rs_data_o[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL post_reset_hold: got %h expected 0000", rs_data_o[0]);
    end
    rd_w_v_i[0] = 1'b1; rd_addr_i[0] = 5'd3; rd_data_i[0] = 16'h00CC;
    tick();
    clr();
    rs_r_v_i[0] = 1'b1; rs_addr_i[0] = 5'd3;
    #1;
    n_cmp++;
    if (rs_data_o[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %h expected 0000", rs_data_o[0]);
    end
    tick();
    clr();
    n_cmp++;
    if (rs_data_o[0] !== 16'h00CC) begin
      n_fail++;
      $display("FAIL post_reset_read: got %h expected 00cc", rs_data_o[0]);
    end
  endtask

  initial begin
    reset_i         = 1'b1;
    rs_r_v_i        = '0;
    rs_addr_i       = '0;
    rd_w_v_i        = '0;
    rd_addr_i       = '0;
    rd_data_i       = '0;
    rd_alloc_v_i    = 1'b0;
    rd_alloc_addr_i = '0;
    tick();
    tick();
    test_reset();
    reset_i = 1'b0;
    tick();
    test_raw();
    test_fwd_priority();
    test_hold_replace();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
